// File: rtl/vga_term_writer_pkg.sv
// Shared definitions for the VGA text-terminal writer.
// Holds the default geometry and blank code, the ASCII control codes the
// writer interprets, the FSM state enumeration and small helper functions.
package vga_term_writer_pkg;

    localparam int         COLS_DEF = 70;
    localparam int         ROWS_DEF = 30;
    localparam logic [7:0] FILL_DEF = 8'h20;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // True for bytes that are stored as glyphs (space through tilde).
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SP) && (b <= ASCII_TILDE);
    endfunction

    // Character-buffer address layout: row in the upper bits, column below.
    function automatic logic [11:0] make_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_term_writer_if.sv
// Byte-input handshake plus character-buffer write port of the terminal writer.
//   in_valid/in_data : producer offers an ASCII byte
//   in_ready         : writer accepts the byte on an edge where both are high
//   wr_en/wr_addr/wr_data : one-cycle write strobe into the character buffer
// The writer uses the slave modport; the producer/buffer side uses master.
interface vga_term_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_term_writer_cursor.sv
// Cursor bookkeeping for the terminal writer.
// Owns the cursor column/row and the scroll base, applies one accepted byte
// when 'apply' is high, and flags when that byte's newline lands on the
// scroll base (the caller must then clear the new row).
//   clk, reset        : clock, asynchronous active-high reset
//   apply, op_byte    : apply op_byte to the cursor this cycle
//   cur_col, cur_row  : registered cursor position
//   scroll_base       : registered physical row shown at the top
//   scroll_req        : combinational, valid while apply is high
module vga_term_cursor
    import vga_term_writer_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apply,
    input  logic [7:0] op_byte,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row,
    output logic [4:0] scroll_base,
    output logic       scroll_req
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    logic       newline_s;
    logic [4:0] row_inc_s;
    logic [4:0] base_inc_s;
    logic [6:0] col_nx_s;
    logic [4:0] row_nx_s;
    logic [4:0] base_nx_s;

    // Modulo-ROWS successors of the cursor row and the scroll base.
    always_comb begin
        row_inc_s  = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;
        base_inc_s = (scroll_base == ROW_LAST) ? 5'd0 : scroll_base + 5'd1;
    end

    // Next cursor/scroll values for the byte being applied.
    always_comb begin
        col_nx_s  = cur_col;
        row_nx_s  = cur_row;
        base_nx_s = scroll_base;
        newline_s = 1'b0;
        if (apply) begin
            if (is_printable(op_byte)) begin
                // The last column wraps to the next line instead of advancing.
                if (cur_col == COL_LAST) begin
                    newline_s = 1'b1;
                end else begin
                    col_nx_s = cur_col + 7'd1;
                end
            end else begin
                case (op_byte)
                    ASCII_LF: newline_s = 1'b1;
                    ASCII_CR: col_nx_s  = 7'd0;
                    ASCII_BS: begin
                        if (cur_col != 7'd0) begin
                            col_nx_s = cur_col - 7'd1;
                        end else begin
                            col_nx_s = cur_col;
                        end
                    end
                    default:  col_nx_s = cur_col;
                endcase
            end
            if (newline_s) begin
                col_nx_s = 7'd0;
                row_nx_s = row_inc_s;
                // Landing on the top display line pushes the view down one row.
                if (row_inc_s == scroll_base) begin
                    base_nx_s = base_inc_s;
                end else begin
                    base_nx_s = scroll_base;
                end
            end else begin
                row_nx_s = cur_row;
            end
        end else begin
            newline_s = 1'b0;
        end
        scroll_req = newline_s && (row_inc_s == scroll_base);
    end

    // Cursor and scroll-base registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_col     <= 7'd0;
            cur_row     <= 5'd0;
            scroll_base <= 5'd0;
        end else begin
            cur_col     <= col_nx_s;
            cur_row     <= row_nx_s;
            scroll_base <= base_nx_s;
        end
    end

endmodule

// File: rtl/vga_term_writer.sv
// VGA text-terminal writer.
// Clears the whole character buffer after reset, then accepts ASCII bytes
// one at a time, writes printable glyphs at the cursor, interprets
// LF / CR / BS, and clears a fresh row whenever the view scrolls.
//   clk, reset   : clock, asynchronous active-high reset
//   bus (slave)  : byte handshake in, character-buffer write strobe out
//   cur_col/row  : cursor position
//   scroll_base  : physical row shown as the top display line
//   busy         : high in every state except IDLE
module vga_term_writer
    import vga_term_writer_pkg::*;
#(
    parameter int         COLS = COLS_DEF,
    parameter int         ROWS = ROWS_DEF,
    parameter logic [7:0] FILL = FILL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    vga_term_writer_if.slave bus,
    output logic [6:0]       cur_col,
    output logic [4:0]       cur_row,
    output logic [4:0]       scroll_base,
    output logic             busy
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    state_t      state_r, state_nx_s;
    logic [4:0]  clr_row_r, clr_row_nx_s;
    logic [6:0]  clr_col_r, clr_col_nx_s;
    logic        clr_done_r, clr_done_nx_s;
    logic [7:0]  byte_r, byte_nx_s;
    logic        wr_en_r, wr_en_nx_s;
    logic [11:0] wr_addr_r, wr_addr_nx_s;
    logic [7:0]  wr_data_r, wr_data_nx_s;
    logic        in_ready_r;
    logic        busy_r;
    logic        apply_s;
    logic        scroll_req_s;

    // The cursor is updated in WRITE, one cycle after the byte's strobe was issued.
    assign apply_s = (state_r == ST_WRITE);

    vga_term_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .apply       (apply_s),
        .op_byte     (byte_r),
        .cur_col     (cur_col),
        .cur_row     (cur_row),
        .scroll_base (scroll_base),
        .scroll_req  (scroll_req_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and next-output logic. Strobes are issued one cycle ahead
    // of their register; clr_done holds INIT/CLEAR for one extra cycle so
    // the final strobe is still seen outside IDLE.
    always_comb begin
        state_nx_s    = state_r;
        clr_row_nx_s  = clr_row_r;
        clr_col_nx_s  = clr_col_r;
        clr_done_nx_s = clr_done_r;
        byte_nx_s     = byte_r;
        wr_en_nx_s    = 1'b0;
        wr_addr_nx_s  = wr_addr_r;
        wr_data_nx_s  = wr_data_r;
        case (state_r)
            ST_INIT: begin
                if (clr_done_r) begin
                    clr_done_nx_s = 1'b0;
                    state_nx_s    = ST_IDLE;
                end else begin
                    wr_en_nx_s   = 1'b1;
                    wr_addr_nx_s = make_addr(clr_row_r, clr_col_r);
                    wr_data_nx_s = FILL;
                    if (clr_col_r == COL_LAST) begin
                        clr_col_nx_s = 7'd0;
                        if (clr_row_r == ROW_LAST) begin
                            clr_row_nx_s  = 5'd0;
                            clr_done_nx_s = 1'b1;
                        end else begin
                            clr_row_nx_s = clr_row_r + 5'd1;
                        end
                    end else begin
                        clr_col_nx_s = clr_col_r + 7'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    byte_nx_s  = bus.in_data;
                    state_nx_s = ST_WRITE;
                    if (is_printable(bus.in_data)) begin
                        wr_en_nx_s   = 1'b1;
                        wr_addr_nx_s = make_addr(cur_row, cur_col);
                        wr_data_nx_s = bus.in_data;
                    end else if ((bus.in_data == ASCII_BS) && (cur_col != 7'd0)) begin
                        wr_en_nx_s   = 1'b1;
                        wr_addr_nx_s = make_addr(cur_row, cur_col - 7'd1);
                        wr_data_nx_s = FILL;
                    end else begin
                        wr_en_nx_s = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (scroll_req_s) begin
                    state_nx_s = ST_CLEAR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // cur_row already holds the freshly scrolled-in row here.
                if (clr_done_r) begin
                    clr_done_nx_s = 1'b0;
                    state_nx_s    = ST_IDLE;
                end else begin
                    wr_en_nx_s   = 1'b1;
                    wr_addr_nx_s = make_addr(cur_row, clr_col_r);
                    wr_data_nx_s = FILL;
                    if (clr_col_r == COL_LAST) begin
                        clr_col_nx_s  = 7'd0;
                        clr_done_nx_s = 1'b1;
                    end else begin
                        clr_col_nx_s = clr_col_r + 7'd1;
                    end
                end
            end
            default: begin
                state_nx_s = ST_INIT;
            end
        endcase
    end

    // Registered outputs, clear counters and the pending byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_row_r  <= 5'd0;
            clr_col_r  <= 7'd0;
            clr_done_r <= 1'b0;
            byte_r     <= 8'h00;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 12'd0;
            wr_data_r  <= 8'h00;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            clr_row_r  <= clr_row_nx_s;
            clr_col_r  <= clr_col_nx_s;
            clr_done_r <= clr_done_nx_s;
            byte_r     <= byte_nx_s;
            wr_en_r    <= wr_en_nx_s;
            wr_addr_r  <= wr_addr_nx_s;
            wr_data_r  <= wr_data_nx_s;
            in_ready_r <= (state_nx_s == ST_IDLE);
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vga_term_writer.sv
// Scoreboard bench for vga_term_writer: a terminal model predicts every
// buffer write and the cursor; a monitor pops and compares each strobe.
module tb_vga_term_writer;

    localparam int         COLS = 70;
    localparam int         ROWS = 30;
    localparam logic [7:0] FILL = 8'h20;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;   // required strobe cycle, -1 when not timed
    } wr_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic [4:0] scroll_base;
    logic       busy;

    vga_term_writer_if bus();

    vga_term_writer #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cur_col     (cur_col),
        .cur_row     (cur_row),
        .scroll_base (scroll_base),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int      cyc = 0;
    int      errors = 0;
    int      checks = 0;
    int      strobes = 0;
    wr_exp_t exp_q[$];
    wr_exp_t mon_e;

    // terminal model state
    int m_col, m_row, m_base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int row, input int col, input logic [7:0] d, input int c);
        wr_exp_t e;
        e.addr = 12'(row * 128 + col);
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    function automatic bit model_will_scroll();
        return ((m_row + 1) % ROWS) == m_base;
    endfunction

    function automatic void model_newline();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        if (m_row == m_base) begin
            m_base = (m_base + 1) % ROWS;
            for (int c = 0; c < COLS; c++) push_exp(m_row, c, FILL, -1);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int strobe_cyc);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_exp(m_row, m_col, b, strobe_cyc);
            if (m_col == COLS - 1) model_newline();
            else m_col = m_col + 1;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                push_exp(m_row, m_col, FILL, strobe_cyc);
            end
        end
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h cyc=%0d", bus.wr_addr, bus.wr_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.data ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    errors++;
                    $display("FAIL write addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                             bus.wr_addr, bus.wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
            checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ready_during_write in_ready=%b busy=%b expected 0/1", bus.in_ready, busy);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b expected 1", bus.in_ready);
        end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            model_byte(b, cyc + 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'h00;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, bus.in_ready}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("pending_writes", exp_q.size(), 32'd0);
        check("cur_col", cur_col, m_col);
        check("cur_row", cur_row, m_row);
        check("scroll_base", scroll_base, m_base);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        strobes = 0;
        #1;
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_wr_addr", bus.wr_addr, 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_cursor", {cur_row, cur_col}, 32'd0);
        check("rst_scroll_base", scroll_base, 32'd0);
        repeat (hold) @(negedge clk);
        reset = 1'b0;
        m_col = 0;
        m_row = 0;
        m_base = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_exp(r, c, FILL, -1);
        wait_idle(3000);
        check("init_strobes", strobes, ROWS * COLS);
    endtask

    initial begin
        int sel;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        do_reset(3);

        // 'A','B' at the top-left, each strobe one cycle after acceptance
        send(8'h41);
        send(8'h42);
        wait_idle(100);

        // backspace handling from column 0
        send(8'h0D);
        send(8'h58);
        send(8'h08);
        send(8'h08);
        wait_idle(100);

        // a full line of printable bytes wraps to the next row, no scroll
        for (int i = 0; i < COLS; i++) send(8'(8'h21 + (i % 90)));
        wait_idle(100);

        // walk down to the last row, then one more newline scrolls
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
        wait_idle(100);
        send(8'h0A);
        wait_idle(200);
        send(8'h0D);
        send(8'h1B);
        wait_idle(100);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (sel <= 5)      send(8'($urandom_range(32, 126)));
            else if (sel == 6) send(8'h0A);
            else if (sel == 7) send(8'h0D);
            else if (sel == 8) send(8'h08);
            else               send(8'($urandom_range(0, 255)));
        end
        wait_idle(200);

        // reset in the middle of a row clear
        for (int i = 0; i < ROWS; i++) begin
            if (!model_will_scroll()) send(8'h0A);
        end
        wait_idle(200);
        send(8'h0A);
        repeat (20) @(negedge clk);
        do_reset(2);
        send(8'h41);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_term_writer.md
VGA_TERM_WRITER -- requirements
Module: vga_term_writer

Interface
REQ-001 Parameter COLS, default 70, number of text columns per row.
REQ-002 Parameter ROWS, default 30, number of text rows in the character buffer.
REQ-003 Parameter FILL, default 8'h20, blank code written when cells are cleared.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  producer offers an ASCII byte.
REQ-007 in_data  input  8  offered ASCII byte.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 wr_en  output  1  one-cycle write strobe to the character buffer.
REQ-010 wr_addr  output  12  buffer address {row[4:0], col[6:0]}.
REQ-011 wr_data  output  8  byte to store at wr_addr.
REQ-012 cur_col  output  7  cursor column, 0..COLS-1.
REQ-013 cur_row  output  5  cursor physical row, 0..ROWS-1.
REQ-014 scroll_base  output  5  physical row shown as the top display line, 0..ROWS-1.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: INIT, IDLE, WRITE, CLEAR.
REQ-017 All outputs are registered; in_ready is high only in IDLE; a byte transfers on an edge where in_valid and in_ready are both high.
REQ-018 INIT writes FILL to every cell, row 0..ROWS-1 outer, col 0..COLS-1 inner, one write per cycle (ROWS*COLS strobes), then enters IDLE.
REQ-019 An accepted byte moves IDLE->WRITE; its wr_en strobe (if any) occurs in the cycle after acceptance; throughput is at most one byte per 2 cycles.
REQ-020 Printable byte (0x20..0x7E): write in_data at {cur_row, cur_col}, then advance cur_col by 1.
REQ-021 Printable byte at cur_col == COLS-1: write it, then perform a newline.
REQ-022 0x0A newline: cur_col <= 0, cur_row <= (cur_row+1) mod ROWS; no write.
REQ-023 0x0D carriage return: cur_col <= 0; no write.
REQ-024 0x08 backspace with cur_col > 0: cur_col <= cur_col-1 and write FILL at the new position; with cur_col == 0: no write, no change.
REQ-025 All other bytes are consumed and ignored: no write, cursor unchanged.
REQ-026 Scroll: when a newline occurs and the new cur_row equals scroll_base, scroll_base <= (scroll_base+1) mod ROWS and the FSM enters CLEAR for the new cur_row.
REQ-027 CLEAR writes FILL to cols 0..COLS-1 of the target row, one per cycle (COLS strobes), then returns to IDLE; in_ready stays low throughout.
REQ-028 Row arithmetic wraps ROWS-1 -> 0; column arithmetic never exceeds COLS-1; address bits above the valid range are never driven with out-of-range values.
REQ-029 wr_en is low in IDLE and in WRITE for bytes that cause no write.

Reset
REQ-030 Asserting reset at any time, including mid-INIT or mid-CLEAR, forces state INIT with the clear counters, cur_col, cur_row and scroll_base at 0, wr_en 0, in_ready 0, busy 1, wr_addr 0, wr_data 0.
REQ-031 After reset release, a full INIT clear restarts from cell {0,0}.

Structure
REQ-032 A shared package holds COLS/ROWS/FILL defaults, ASCII constants (BS 8'h08, LF 8'h0A, CR 8'h0D), and the FSM state enumeration.
REQ-033 One sub-module, vga_term_cursor, owns cur_col, cur_row, scroll_base and their modulo arithmetic; it reports the scroll-required condition to the FSM.

Verification
REQ-034 Release reset -> exactly 2100 wr_en strobes of 8'h20 covering {0,0}..{29,69}, then in_ready rises with busy 0.
REQ-035 Send 'A','B' -> writes 8'h41 @ {0,0}, 8'h42 @ {0,1}; cur_col 2; each strobe one cycle after its acceptance.
REQ-036 70 printable bytes from {0,0} -> last written at {0,69}; cursor ends at {1,0}; no scroll.
REQ-037 Send 'X', 0x08, 0x08 -> writes 'X' @ {0,0} then 8'h20 @ {0,0}; second backspace produces no write; cur_col 0.
REQ-038 From cur_row 29, scroll_base 0, send 0x0A -> cur_row 0, scroll_base 1, 70 FILL writes to row 0, in_ready low until done; 0x0D 0x1B produce no writes.
REQ-039 Assert reset midway through a CLEAR -> wr_en drops immediately; after release, full INIT clear restarts at {0,0} with cursor {0,0}, scroll_base 0.
